// File: rtl/sys_array_pkg.sv
// Shared definitions for the output-stationary systolic array.
package sys_array_pkg;

  localparam int unsigned DefaultRow  = 4;
  localparam int unsigned DefaultCol  = 4;
  localparam int unsigned DefaultEs   = 8;
  localparam int unsigned DefaultKMax = 64;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StFlush,
    StDrain
  } state_e;

endpackage

// File: rtl/systolic_array_os_if.sv
// Job control, operand stream and result stream of the systolic array.
interface systolic_array_os_if
  import sys_array_pkg::*;
#(
  parameter int unsigned ROW   = DefaultRow,
  parameter int unsigned COL   = DefaultCol,
  parameter int unsigned ES    = DefaultEs,
  parameter int unsigned K_MAX = DefaultKMax,
  parameter int unsigned ACC_W = 2 * ES + $clog2(K_MAX)
);
  localparam int unsigned KW = $clog2(K_MAX + 1);
  localparam int unsigned RW = $clog2(ROW);

  logic                 start;
  logic [KW-1:0]        k_len;
  logic                 signed_mode;
  logic                 in_vld;
  logic                 in_rdy;
  logic [ROW*ES-1:0]    a_vec;
  logic [COL*ES-1:0]    b_vec;
  logic                 out_vld;
  logic                 out_rdy;
  logic [COL*ACC_W-1:0] out_row;
  logic [RW-1:0]        out_row_idx;
  logic                 out_last;
  logic                 busy;
  logic                 done;

  modport master (
    output start, k_len, signed_mode, in_vld, a_vec, b_vec, out_rdy,
    input  in_rdy, out_vld, out_row, out_row_idx, out_last, busy, done
  );

  modport slave (
    input  start, k_len, signed_mode, in_vld, a_vec, b_vec, out_rdy,
    output in_rdy, out_vld, out_row, out_row_idx, out_last, busy, done
  );

endinterface

// File: rtl/pe_mac.sv
// One multiply-accumulate cell: registered a/b pass-through plus a local accumulator.
module pe_mac #(
  parameter int unsigned ES    = 8,
  parameter int unsigned ACC_W = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_signed,
  input  logic [ES-1:0]    i_a,
  input  logic             i_a_vld,
  input  logic [ES-1:0]    i_b,
  input  logic             i_b_vld,
  output logic [ES-1:0]    o_a,
  output logic             o_a_vld,
  output logic [ES-1:0]    o_b,
  output logic             o_b_vld,
  output logic [ACC_W-1:0] o_acc
);

  logic signed [ES:0]     w_a_ext;
  logic signed [ES:0]     w_b_ext;
  logic signed [2*ES+1:0] w_prod;
  logic [ACC_W-1:0]       w_prod_ext;
  logic [ES-1:0]          r_a;
  logic [ES-1:0]          r_b;
  logic                   r_a_vld;
  logic                   r_b_vld;
  logic [ACC_W-1:0]       r_acc;

  // One extra bit lets a single signed multiplier cover both modes.
  assign w_a_ext    = {i_signed & i_a[ES-1], i_a};
  assign w_b_ext    = {i_signed & i_b[ES-1], i_b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {{(ACC_W - 2 * ES - 2){w_prod[2*ES+1]}}, w_prod};

  // Forward operands one hop and accumulate on a matched operand pair.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_a_vld <= 1'b0;
      r_b_vld <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_a_vld <= i_a_vld;
      r_b_vld <= i_b_vld;
      if (i_clr) begin
        r_acc <= '0;
      end else if (i_a_vld && i_b_vld) begin
        r_acc <= r_acc + w_prod_ext;
      end
    end
  end

  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_a_vld = r_a_vld;
  assign o_b_vld = r_b_vld;
  assign o_acc   = r_acc;

endmodule

// File: rtl/systolic_array_os.sv
// Output-stationary ROW x COL systolic matrix multiplier, C = A * B, drained row by row.
module systolic_array_os
  import sys_array_pkg::*;
#(
  parameter int unsigned ROW   = DefaultRow,
  parameter int unsigned COL   = DefaultCol,
  parameter int unsigned ES    = DefaultEs,
  parameter int unsigned K_MAX = DefaultKMax,
  parameter int unsigned ACC_W = 2 * ES + $clog2(K_MAX)
) (
  input logic               clk,
  input logic               rst_n,
  systolic_array_os_if.slave bus
);

  localparam int unsigned KW = $clog2(K_MAX + 1);
  localparam int unsigned RW = $clog2(ROW);
  localparam int unsigned FW = $clog2(ROW + COL);

  state_e               r_state, w_state_d;
  logic [KW-1:0]        r_k_tgt, r_k_cnt, w_k_clamp;
  logic [FW-1:0]        r_flush_cnt;
  logic [RW-1:0]        r_row_idx;
  logic                 r_signed;
  logic                 w_start, w_fire, w_in_rdy, w_out_vld, w_busy, w_done;
  logic [COL*ACC_W-1:0] w_row;
  logic                 w_unused_edge;

  logic [ES-1:0]    w_a   [ROW][COL+1];
  logic             w_av  [ROW][COL+1];
  logic [ES-1:0]    w_b   [ROW+1][COL];
  logic             w_bv  [ROW+1][COL];
  logic [ACC_W-1:0] w_acc [ROW][COL];

  assign w_k_clamp = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
  assign w_fire    = bus.in_vld & w_in_rdy;

  // Next-state and handshake decode.
  always_comb begin
    w_state_d = r_state;
    w_in_rdy  = 1'b0;
    w_out_vld = 1'b0;
    w_busy    = 1'b1;
    w_done    = 1'b0;
    w_start   = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_start   = 1'b1;
          w_state_d = (w_k_clamp == '0) ? StDrain : StFeed;
        end
      end
      StFeed: begin
        w_in_rdy = 1'b1;
        if (w_fire && (r_k_cnt == r_k_tgt - KW'(1))) w_state_d = StFlush;
      end
      StFlush: begin
        if (r_flush_cnt == FW'(ROW + COL - 2)) w_state_d = StDrain;
      end
      StDrain: begin
        w_out_vld = 1'b1;
        if (bus.out_rdy && (r_row_idx == RW'(ROW - 1))) begin
          w_done    = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State register, job parameters and beat/flush/row counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_k_tgt     <= '0;
      r_k_cnt     <= '0;
      r_flush_cnt <= '0;
      r_row_idx   <= '0;
      r_signed    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_start) begin
        r_k_tgt  <= w_k_clamp;
        r_k_cnt  <= '0;
        r_signed <= bus.signed_mode;
      end else if (w_fire) begin
        r_k_cnt <= r_k_cnt + KW'(1);
      end
      r_flush_cnt <= (r_state == StFlush) ? r_flush_cnt + FW'(1) : '0;
      if (r_state == StIdle) begin
        r_row_idx <= '0;
      end else if (w_out_vld && bus.out_rdy) begin
        r_row_idx <= r_row_idx + RW'(1);
      end
    end
  end

  // Input skew: A lane r and B lane c enter the array r and c cycles late respectively.
  for (genvar gr = 0; gr < ROW; gr++) begin : g_a_skew
    if (gr == 0) begin : g_direct
      assign w_a[0][0]  = bus.a_vec[ES-1:0];
      assign w_av[0][0] = w_fire;
    end else begin : g_dly
      logic [ES-1:0] r_sh  [gr];
      logic          r_vsh [gr];
      // Shift lane data and beat valid together.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < gr; i++) begin
            r_sh[i]  <= '0;
            r_vsh[i] <= 1'b0;
          end
        end else begin
          r_sh[0]  <= bus.a_vec[gr*ES +: ES];
          r_vsh[0] <= w_fire;
          for (int i = 1; i < gr; i++) begin
            r_sh[i]  <= r_sh[i-1];
            r_vsh[i] <= r_vsh[i-1];
          end
        end
      end
      assign w_a[gr][0]  = r_sh[gr-1];
      assign w_av[gr][0] = r_vsh[gr-1];
    end
  end

  for (genvar gc = 0; gc < COL; gc++) begin : g_b_skew
    if (gc == 0) begin : g_direct
      assign w_b[0][0]  = bus.b_vec[ES-1:0];
      assign w_bv[0][0] = w_fire;
    end else begin : g_dly
      logic [ES-1:0] r_sh  [gc];
      logic          r_vsh [gc];
      // Shift lane data and beat valid together.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < gc; i++) begin
            r_sh[i]  <= '0;
            r_vsh[i] <= 1'b0;
          end
        end else begin
          r_sh[0]  <= bus.b_vec[gc*ES +: ES];
          r_vsh[0] <= w_fire;
          for (int i = 1; i < gc; i++) begin
            r_sh[i]  <= r_sh[i-1];
            r_vsh[i] <= r_vsh[i-1];
          end
        end
      end
      assign w_b[0][gc]  = r_sh[gc-1];
      assign w_bv[0][gc] = r_vsh[gc-1];
    end
  end

  for (genvar gr = 0; gr < ROW; gr++) begin : g_row
    for (genvar gc = 0; gc < COL; gc++) begin : g_col
      pe_mac #(
        .ES   (ES),
        .ACC_W(ACC_W)
      ) u_pe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_start),
        .i_signed(r_signed),
        .i_a     (w_a[gr][gc]),
        .i_a_vld (w_av[gr][gc]),
        .i_b     (w_b[gr][gc]),
        .i_b_vld (w_bv[gr][gc]),
        .o_a     (w_a[gr][gc+1]),
        .o_a_vld (w_av[gr][gc+1]),
        .o_b     (w_b[gr+1][gc]),
        .o_b_vld (w_bv[gr+1][gc]),
        .o_acc   (w_acc[gr][gc])
      );
    end
  end

  // Operands leaving the right and bottom edges have no consumer.
  always_comb begin
    w_unused_edge = 1'b0;
    for (int r = 0; r < ROW; r++) w_unused_edge = w_unused_edge ^ (^w_a[r][COL]) ^ w_av[r][COL];
    for (int c = 0; c < COL; c++) w_unused_edge = w_unused_edge ^ (^w_b[ROW][c]) ^ w_bv[ROW][c];
  end

  // Select the accumulator row being drained; zero outside DRAIN.
  always_comb begin
    w_row = '0;
    if (r_state == StDrain) begin
      for (int c = 0; c < COL; c++) w_row[c*ACC_W +: ACC_W] = w_acc[r_row_idx][c];
    end
  end

  assign bus.in_rdy      = w_in_rdy;
  assign bus.out_vld     = w_out_vld;
  assign bus.out_row     = w_row;
  assign bus.out_row_idx = r_row_idx;
  assign bus.out_last    = w_out_vld && (r_row_idx == RW'(ROW - 1));
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;

endmodule

// File: tb/tb_systolic_array_os.sv
// Scoreboard bench for systolic_array_os: directed jobs, expected rows queued at issue time.
module tb_systolic_array_os;

  localparam int unsigned ROW   = 4;
  localparam int unsigned COL   = 4;
  localparam int unsigned ES    = 8;
  localparam int unsigned K_MAX = 64;
  localparam int unsigned ACC_W = 22;

  typedef struct {
    logic [COL*ACC_W-1:0] row;
    int                   idx;
    bit                   last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rdy_rand = 1'b0;
  int   lat_n;
  bit   seen;
  bit   got;

  logic [ES-1:0] ma [ROW][K_MAX];
  logic [ES-1:0] mb [K_MAX][COL];
  longint        exp_c [ROW][COL];
  exp_t          exp_q [$];

  always #5 clk = ~clk;

  systolic_array_os_if #(
    .ROW(ROW), .COL(COL), .ES(ES), .K_MAX(K_MAX), .ACC_W(ACC_W)
  ) bus ();

  systolic_array_os #(
    .ROW(ROW), .COL(COL), .ES(ES), .K_MAX(K_MAX), .ACC_W(ACC_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_all(input logic [ES-1:0] va, input logic [ES-1:0] vb);
    for (int r = 0; r < ROW; r++) for (int k = 0; k < K_MAX; k++) ma[r][k] = va;
    for (int k = 0; k < K_MAX; k++) for (int c = 0; c < COL; c++) mb[k][c] = vb;
  endtask

  task automatic set_exp(input longint v);
    for (int r = 0; r < ROW; r++) for (int c = 0; c < COL; c++) exp_c[r][c] = v;
  endtask

  task automatic model(input int k, input bit sm);
    for (int r = 0; r < ROW; r++) begin
      for (int c = 0; c < COL; c++) begin
        longint s = 0;
        for (int i = 0; i < k; i++) begin
          longint a = sm ? longint'($signed(ma[r][i])) : longint'(ma[r][i]);
          longint b = sm ? longint'($signed(mb[i][c])) : longint'(mb[i][c]);
          s += a * b;
        end
        exp_c[r][c] = s;
      end
    end
  endtask

  task automatic push_exp();
    for (int r = 0; r < ROW; r++) begin
      exp_t e;
      e.row = '0;
      for (int c = 0; c < COL; c++) begin
        longint v = exp_c[r][c];
        e.row[c*ACC_W +: ACC_W] = v[ACC_W-1:0];
      end
      e.idx  = r;
      e.last = (r == ROW - 1);
      exp_q.push_back(e);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic do_start(input int k, input bit sm);
    bus.start       = 1'b1;
    bus.k_len       = 7'(k);
    bus.signed_mode = sm;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic feed(input int k, input bit gaps);
    for (int i = 0; i < k; i++) begin
      bit acc;
      int t;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_vld = 1'b0;
          bus.a_vec  = $urandom;
          bus.b_vec  = $urandom;
          @(posedge clk); #1;
        end
      end
      bus.in_vld = 1'b1;
      for (int r = 0; r < ROW; r++) bus.a_vec[r*ES +: ES] = ma[r][i];
      for (int c = 0; c < COL; c++) bus.b_vec[c*ES +: ES] = mb[i][c];
      t = 0;
      do begin
        @(negedge clk);
        acc = bus.in_rdy;
        @(posedge clk); #1;
        t++;
      end while (!acc && t < 50);
      if (!acc) chk("beat_accept_timeout", 0, 1);
    end
    bus.in_vld = 1'b0;
  endtask

  task automatic wait_done();
    bit d = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (bus.done) begin
        d = 1'b1;
        break;
      end
    end
    chk("done_seen", d, 1);
    @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("idle_after_done", bus.busy, 0);
  endtask

  // Scoreboard monitor: the head entry must be on the bus whenever out_vld is high.
  always @(negedge clk) begin
    if (rst_n && bus.out_vld) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out: out_vld=1 idx=%0d, expected no output", bus.out_row_idx);
      end else begin
        n_checks++;
        if (bus.out_row !== exp_q[0].row) begin
          n_errors++;
          $display("FAIL out_row: got %h, expected %h (idx %0d)", bus.out_row, exp_q[0].row,
                   exp_q[0].idx);
        end
        chk("out_row_idx", bus.out_row_idx, exp_q[0].idx);
        chk("out_last", bus.out_last, exp_q[0].last);
        if (bus.out_rdy) begin
          exp_t e;
          chk("done_on_beat", bus.done, exp_q[0].last);
          e = exp_q.pop_front();
        end else begin
          chk("done_while_stalled", bus.done, 0);
        end
      end
    end
  end

  always begin
    @(posedge clk); #2;
    if (rdy_rand) bus.out_rdy = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.k_len       = '0;
    bus.signed_mode = 1'b0;
    bus.in_vld      = 1'b0;
    bus.a_vec       = '0;
    bus.b_vec       = '0;
    bus.out_rdy     = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_rdy", bus.in_rdy, 0);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_row_idx", bus.out_row_idx, 0);
    chk("rst_out_row_zero", (bus.out_row == '0), 1);
    @(posedge clk); #1;

    // Identity A, B[k][c] = 4k+c; junk in_vld during FLUSH must be ignored.
    for (int r = 0; r < ROW; r++) for (int k = 0; k < K_MAX; k++) ma[r][k] = (r == k) ? 8'd1 : 8'd0;
    for (int k = 0; k < K_MAX; k++) for (int c = 0; c < COL; c++) mb[k][c] = 8'(k * 4 + c);
    for (int r = 0; r < ROW; r++) for (int c = 0; c < COL; c++) exp_c[r][c] = r * 4 + c;
    push_exp();
    fork
      begin
        do_start(4, 1'b0);
        feed(4, 1'b0);
        bus.in_vld = 1'b1;
        bus.a_vec  = '1;
        bus.b_vec  = '1;
        @(negedge clk);
        chk("in_rdy_in_flush", bus.in_rdy, 0);
        repeat (4) @(posedge clk);
        #1 bus.in_vld = 1'b0;
      end
      begin
        lat_n = 0;
        forever begin
          @(posedge clk);
          lat_n++;
          @(negedge clk);
          if (bus.out_vld || lat_n >= 100) break;
        end
        chk("first_vld_latency", lat_n, 12);
      end
    join
    wait_done();

    // All 8'hFF, k=64: signed then unsigned.
    set_all(8'hFF, 8'hFF);
    set_exp(64);
    push_exp();
    do_start(64, 1'b1);
    feed(64, 1'b0);
    wait_done();
    set_exp(4161600);
    push_exp();
    do_start(64, 1'b0);
    feed(64, 1'b0);
    wait_done();

    // Random operands with input gaps and output backpressure.
    for (int pass = 0; pass < 2; pass++) begin
      int k = (pass == 0) ? 8 : 5;
      bit sm = (pass == 0);
      for (int r = 0; r < ROW; r++) for (int i = 0; i < K_MAX; i++) ma[r][i] = 8'($urandom);
      for (int i = 0; i < K_MAX; i++) for (int c = 0; c < COL; c++) mb[i][c] = 8'($urandom);
      model(k, sm);
      push_exp();
      rdy_rand = 1'b1;
      do_start(k, sm);
      feed(k, 1'b1);
      wait_done();
      rdy_rand    = 1'b0;
      bus.out_rdy = 1'b1;
    end

    // k_len = 0: straight to DRAIN, all-zero rows even after a nonzero job.
    set_exp(0);
    push_exp();
    do_start(0, 1'b0);
    @(negedge clk);
    chk("k0_drain_next_cycle", bus.out_vld, 1);
    wait_done();

    // k_len above K_MAX clamps to K_MAX beats.
    set_all(8'd1, 8'd1);
    set_exp(64);
    push_exp();
    do_start(100, 1'b0);
    feed(64, 1'b0);
    @(negedge clk);
    chk("clamp_feed_closed", bus.in_rdy, 0);
    @(posedge clk); #1;
    wait_done();

    // Reset during FLUSH abandons the job.
    do_start(4, 1'b0);
    feed(4, 1'b0);
    @(negedge clk);
    chk("busy_in_flush", bus.busy, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_vld) seen = 1'b1;
    end
    chk("no_vld_after_reset", seen, 0);
    chk("busy_after_reset", bus.busy, 0);
    @(posedge clk); #1;
    set_exp(2);
    push_exp();
    do_start(2, 1'b0);
    feed(2, 1'b0);
    wait_done();

    // Back-to-back: start held high from job 1 through its final handshake.
    set_all(8'd3, 8'd5);
    set_exp(15);
    push_exp();
    set_exp(28);
    push_exp();
    bus.start       = 1'b1;
    bus.k_len       = 7'd1;
    bus.signed_mode = 1'b0;
    @(posedge clk); #1;
    bus.k_len = 7'd2;
    feed(1, 1'b0);
    set_all(8'd2, 8'd7);
    got = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    chk("b2b_first_done", got, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_idle_gap", bus.busy, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_second_accepted", bus.in_rdy, 1);
    feed(2, 1'b0);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/systolic_array_os.md
SYSTOLIC_ARRAY_OS -- requirements
Module: systolic_array_os

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  ROW, 4, array rows, i.e. output matrix rows
  COL, 4, array columns, i.e. output matrix columns
  ES, 8, operand element width
  K_MAX, 64, maximum inner dimension
  ACC_W, 2*ES+$clog2(K_MAX), accumulator width
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk, in, 1, the single clock
  rst_n, in, 1, synchronous active-low reset
  start, in, 1, begin a job; sampled in IDLE only
  k_len, in, $clog2(K_MAX+1), inner dimension; sampled with start
  signed_mode, in, 1, 1 = two's-complement operands; sampled with start
  in_vld, in, 1, operand beat valid
  in_rdy, out, 1, operand beat accepted when in_vld and in_rdy are both 1
  a_vec, in, ROW*ES, column k of A; lane r = A[r][k]
  b_vec, in, COL*ES, row k of B; lane c = B[k][c]
  out_vld, out, 1, output row valid
  out_rdy, in, 1, output row consumed when out_vld and out_rdy are both 1
  out_row, out, COL*ACC_W, C[row_idx][0..COL-1]; lane c = C[row_idx][c]
  out_row_idx, out, $clog2(ROW), index of the row currently on out_row
  out_last, out, 1, high on the beat carrying row ROW-1
  busy, out, 1, high in any state other than IDLE
  done, out, 1, one-cycle pulse on the final accepted output beat

Function
REQ-003 FSM states: IDLE, FEED, FLUSH, DRAIN.
REQ-004 IDLE: when start=1, capture k_len into k_cnt target, clear all accumulators, go to FEED (go to DRAIN if k_len=0).
REQ-005 k_len > K_MAX shall be treated as K_MAX.
REQ-006 FEED: in_rdy=1. The block accepts exactly k_len beats, then goes to FLUSH. in_vld gaps stall injection without corrupting results.
REQ-007 Internal skew: lane r of a_vec is delayed r cycles into PE(r,0). Lane c of b_vec is delayed c cycles into PE(0,c). The operand valid is skewed identically. Callers supply unskewed data.
REQ-008 PE(r,c): acc <= acc + a*b when its a-valid and b-valid are both 1. It forwards a right and b down, each with valid, with a 1-cycle register per hop.
REQ-009 Products are signed or unsigned per the latched signed_mode. Accumulators sign-extend or zero-extend accordingly. With k_len <= K_MAX no overflow is possible.
REQ-010 FLUSH lasts exactly ROW+COL-1 cycles after the last accepted beat, then goes to DRAIN.
REQ-011 DRAIN: out_vld=1, row index starts at 0, and out_row, out_row_idx and out_last stay stable until out_rdy=1. Each accepted beat increments the index.
REQ-012 The accepted beat with index ROW-1 pulses done, and the FSM returns to IDLE on the next cycle.
REQ-013 in_rdy=0 outside FEED. in_vld outside FEED is ignored.
REQ-014 start outside IDLE is ignored, including start in the same cycle as the final DRAIN handshake.
REQ-015 Latency with no stalls: first out_vld occurs k_len+ROW+COL cycles after the start cycle.

Reset
REQ-016 When rst_n=0 at a clk edge, all of the following shall be cleared to 0: the FSM (to IDLE), all counters, all skew registers, all PE accumulators and valids, and outputs in_rdy, out_vld, out_row, out_row_idx, out_last, busy and done.
REQ-017 Reset mid-job (any state) abandons the job. No out_vld shall appear until a new start.

Structure
REQ-018 Package sys_array_pkg shall hold the FSM state enum and the default ROW, COL, ES and K_MAX localparams.
REQ-019 One sub-module, pe_mac: a single MAC cell with a/b pass-through, valid propagation, an accumulator clear input and a signed_mode input. The top level instantiates ROW*COL of them in a generate loop.

Verification
REQ-020 Identity: A=I4, B[k][c]=k*4+c, k_len=4, unsigned, out_rdy=1 -> rows out as {0,1,2,3},{4,5,6,7},{8,9,10,11},{12,13,14,15}; out_last and done on the 4th beat; first out_vld at start+12.
REQ-021 Signed: every A and B element = 8'hFF, signed_mode=1, k_len=64 -> every C element = +64. The same with signed_mode=0 -> every element = 64*65025 = 4161600.
REQ-022 Backpressure and gaps: random in_vld gaps in FEED and random out_rdy -> results equal a golden model, and out_row/out_row_idx stay stable while out_rdy=0.
REQ-023 k_len=0: start -> DRAIN within 1 cycle; four all-zero rows; done pulses.
REQ-024 Reset in FLUSH: rst_n low 1 cycle -> out_vld never rises. A new start with A=B=all-ones and k_len=2 -> all elements = 2, with no residue from the aborted job.
REQ-025 Back-to-back: a second start held high through the final DRAIN handshake -> ignored in that cycle and accepted in IDLE the next cycle. The second job's accumulators start from 0.
